// File: rtl/m_store_buf_pkg.sv
// Shared definitions for the M-stage store buffer: store-op codes,
// byte-enable constants and the layout of one buffered entry.
package m_store_buf_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_SB   = 2'b01,
    OP_SH   = 2'b10,
    OP_SW   = 2'b11
  } store_op_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // One queued store; only the word address is kept because DM writes
  // are always word-aligned and the lane selection lives in byteen.
  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/m_store_fmt.sv
// Combinational store formatter: maps op / low address bits / raw store
// data to byte enables, lane-replicated write data and a misalignment flag.
module m_store_fmt
  import m_store_buf_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  output logic [3:0]  byteen,
  output logic [31:0] wdata,
  output logic        misaligned
);

  // Decode op into lane enables and replicated data; NONE yields nothing.
  always_comb begin
    byteen     = BE_NONE;
    wdata      = 32'h0;
    misaligned = 1'b0;
    case (store_op_e'(op))
      OP_SB: begin
        byteen = BE_BYTE0 << addr_lo;
        wdata  = {4{wd[7:0]}};
      end
      OP_SH: begin
        byteen     = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
        wdata      = {2{wd[15:0]}};
        misaligned = addr_lo[0];
      end
      OP_SW: begin
        byteen     = BE_WORD;
        wdata      = wd;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        byteen     = BE_NONE;
        wdata      = 32'h0;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/m_store_buf.sv
// M-stage store buffer: formats sb/sh/sw into word-aligned writes, queues
// them in a DEPTH-entry FIFO draining to the data memory, stalls M when
// full, flags misaligned stores and detects loads aliasing buffered words.
//
// DM handshake: dm_valid/dm_ready is a strict valid/ready pair. The head
// entry transfers on a cycle where both are high; while dm_valid is high
// and dm_ready is low, every dm_* output holds its value. dm_valid never
// depends on dm_ready.
//
// DEPTH must be 2, 4 or 8 so pointers wrap naturally at their width.
module m_store_buf
  import m_store_buf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_store_valid,
  input  logic [1:0]  M_store_op,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_WD,
  input  logic [31:0] M_PC,
  input  logic        M_load_valid,
  input  logic [31:0] M_load_addr,
  output logic        M_stall,
  output logic        M_load_hit,
  output logic        M_ades,
  output logic        dm_valid,
  input  logic        dm_ready,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  output logic [31:0] dm_pc,
  output logic [3:0]  buf_count
);

  localparam int         PW        = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

  sb_entry_t         mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [3:0]        count;

  logic [3:0]        fmt_byteen;
  logic [31:0]       fmt_wdata;
  logic              fmt_misaligned;

  logic              req;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic              full;
  sb_entry_t         head;
  sb_entry_t         new_entry;
  logic              hit_any;
  logic [PW-1:0]     slot_off;

  // The byte offset of a load never matters to the word-level alias check.
  logic [1:0]        load_lo_unused;
  assign load_lo_unused = M_load_addr[1:0];

  m_store_fmt u_fmt (
    .op         (M_store_op),
    .addr_lo    (M_addr[1:0]),
    .wd         (M_WD),
    .byteen     (fmt_byteen),
    .wdata      (fmt_wdata),
    .misaligned (fmt_misaligned)
  );

  // Request qualification, push/pop decisions and the M-stage handshakes.
  // Every output is forced low while reset is asserted.
  always_comb begin
    full       = (count == DEPTH_CNT);
    head_valid = !reset && (count != 4'd0);
    pop        = head_valid && dm_ready;
    req        = !reset && M_store_valid &&
                 (M_store_op != OP_NONE) && !fmt_misaligned;
    push       = req && (!full || pop);
    M_stall    = req && full && !pop;
    M_ades     = !reset && M_store_valid && fmt_misaligned;
    new_entry  = '{word_addr: M_addr[31:2], wdata: fmt_wdata,
                   byteen: fmt_byteen, pc: M_PC};
  end

  // Head entry drives DM; it is registered, so a push into an empty
  // buffer shows up on dm_* one cycle later.
  always_comb begin
    head      = mem[rd_ptr];
    dm_valid  = head_valid;
    dm_addr   = reset ? 32'h0 : {head.word_addr, 2'b00};
    dm_wdata  = reset ? 32'h0 : head.wdata;
    dm_byteen = reset ? 4'h0  : head.byteen;
    dm_pc     = reset ? 32'h0 : head.pc;
    buf_count = reset ? 4'h0  : count;
  end

  // Alias check of the incoming load against every occupied entry; an
  // entry leaving this cycle is still occupied and still counts.
  always_comb begin
    hit_any  = 1'b0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PW'(i) - rd_ptr;
      if ((4'(slot_off) < count) &&
          (mem[i].word_addr == M_load_addr[31:2]))
        hit_any = 1'b1;
    end
    M_load_hit = !reset && M_load_valid && hit_any;
  end

  // FIFO state: storage, pointers and occupancy. Reset discards everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
